// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S frame constants and types
// Purpose: frame geometry and slot type shared by the I2S transmitter and receiver.
// Ports: none (package).
package i2s_pkg;

  localparam int SAMPLE_W        = 16;
  localparam int SLOTS_PER_FRAME = 64;
  localparam int SLOTS_PER_CH    = 32;
  localparam int SLOT_W          = $clog2(SLOTS_PER_FRAME);

  typedef logic [SLOT_W-1:0] slot_t;

  localparam slot_t SLOT_LAST = slot_t'(SLOTS_PER_FRAME - 1);

endpackage

// File: rtl/i2s_clk_gen.sv
// rtl/i2s_clk_gen.sv - I2S bit clock, word select and slot counter generator
// Purpose: divides clk_in into BCLK, counts 64 slots per frame on BCLK falling
//          edges and drives LRCLK so it only moves on those falling edges.
// Ports:
//   clk_in        system clock, all logic on its rising edge
//   rst_in        asynchronous active-low reset
//   bclk_out      bit clock
//   lrclk_out     word select, low for slots 0..31, high for 32..63
//   slot_out      current slot number
//   slot_next_out slot number entered at the next BCLK falling edge
//   bclk_fall_out high in the clk_in cycle whose rising edge drops BCLK
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int BCLK_HALF = 12
) (
  input  logic  clk_in,
  input  logic  rst_in,
  output logic  bclk_out,
  output logic  lrclk_out,
  output slot_t slot_out,
  output slot_t slot_next_out,
  output logic  bclk_fall_out
);

  localparam logic [7:0] DIV_LAST = 8'(BCLK_HALF - 1);

  logic [7:0] div_q, div_d;
  logic       bclk_q, bclk_d;
  logic       lrclk_q, lrclk_d;
  slot_t      slot_q, slot_d;
  slot_t      slot_next;
  logic       div_wrap;
  logic       bclk_fall;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      div_q   <= '0;
      bclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
      // Parked on the last slot so the first falling edge opens slot 0.
      slot_q  <= SLOT_LAST;
    end else begin
      div_q   <= div_d;
      bclk_q  <= bclk_d;
      lrclk_q <= lrclk_d;
      slot_q  <= slot_d;
    end
  end

  always_comb begin
    div_wrap  = (div_q == DIV_LAST);
    div_d     = div_wrap ? 8'd0 : div_q + 8'd1;
    bclk_d    = div_wrap ? ~bclk_q : bclk_q;
    bclk_fall = div_wrap & bclk_q;
    slot_next = slot_q + slot_t'(1);
    slot_d    = bclk_fall ? slot_next : slot_q;
    // Upper half of the frame is the right channel; MSB of the slot says which.
    lrclk_d   = bclk_fall ? slot_next[SLOT_W-1] : lrclk_q;
  end

  assign bclk_out      = bclk_q;
  assign lrclk_out     = lrclk_q;
  assign slot_out      = slot_q;
  assign slot_next_out = slot_next;
  assign bclk_fall_out = bclk_fall;

endmodule

// File: rtl/i2s_transmitter.sv
// rtl/i2s_transmitter.sv - Philips I2S stereo transmitter
// Purpose: buffers one pending stereo pair, commits it at each frame start and
//          serialises it MSB first with a one-bit delay after each LRCLK edge.
// Ports:
//   clk_in           system clock
//   rst_in           asynchronous active-low reset
//   left_sample_in   left sample (LRCLK low)
//   right_sample_in  right sample (LRCLK high)
//   new_sample_in    one-cycle pulse qualifying both samples
//   i2s_bclk_out     bit clock
//   i2s_lrclk_out    word select
//   i2s_data_out     serial data
//   frame_start_out  pulse when a frame's samples are committed
//   underrun_out     pulse when a frame repeats stale samples
//   overrun_out      pulse when a pending pair is overwritten
module i2s_transmitter #(
  parameter int BCLK_HALF = 12,
  parameter int SAMPLE_W  = i2s_pkg::SAMPLE_W
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [SAMPLE_W-1:0] left_sample_in,
  input  logic [SAMPLE_W-1:0] right_sample_in,
  input  logic                new_sample_in,
  output logic                i2s_bclk_out,
  output logic                i2s_lrclk_out,
  output logic                i2s_data_out,
  output logic                frame_start_out,
  output logic                underrun_out,
  output logic                overrun_out
);

  import i2s_pkg::*;

  localparam slot_t L_FIRST = slot_t'(1);
  localparam slot_t L_LAST  = slot_t'(SAMPLE_W);
  localparam slot_t R_LOAD  = slot_t'(SLOTS_PER_CH);
  localparam slot_t R_FIRST = slot_t'(SLOTS_PER_CH + 1);
  localparam slot_t R_LAST  = slot_t'(SLOTS_PER_CH + SAMPLE_W);

  slot_t slot, slot_next;
  logic  bclk_fall;
  logic  commit;
  logic  in_data_slot;

  logic [SAMPLE_W-1:0] pend_l_q, pend_l_d;
  logic [SAMPLE_W-1:0] pend_r_q, pend_r_d;
  logic                pend_valid_q, pend_valid_d;
  logic [SAMPLE_W-1:0] act_l_q, act_l_d;
  logic [SAMPLE_W-1:0] act_r_q, act_r_d;
  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic                data_q, data_d;
  logic                frame_start_q, frame_start_d;
  logic                underrun_q, underrun_d;

  i2s_clk_gen #(
    .BCLK_HALF(BCLK_HALF)
  ) u_clk_gen (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .bclk_out     (i2s_bclk_out),
    .lrclk_out    (i2s_lrclk_out),
    .slot_out     (slot),
    .slot_next_out(slot_next),
    .bclk_fall_out(bclk_fall)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pend_l_q      <= '0;
      pend_r_q      <= '0;
      pend_valid_q  <= 1'b0;
      act_l_q       <= '0;
      act_r_q       <= '0;
      shift_q       <= '0;
      data_q        <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      pend_l_q      <= pend_l_d;
      pend_r_q      <= pend_r_d;
      pend_valid_q  <= pend_valid_d;
      act_l_q       <= act_l_d;
      act_r_q       <= act_r_d;
      shift_q       <= shift_d;
      data_q        <= data_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  always_comb begin
    pend_l_d     = pend_l_q;
    pend_r_d     = pend_r_q;
    pend_valid_d = pend_valid_q;
    act_l_d      = act_l_q;
    act_r_d      = act_r_q;
    shift_d      = shift_q;
    data_d       = data_q;

    commit       = bclk_fall & (slot == SLOT_LAST);
    in_data_slot = ((slot_next >= L_FIRST) && (slot_next <= L_LAST)) ||
                   ((slot_next >= R_FIRST) && (slot_next <= R_LAST));

    // Commit consumes the pending pair as it stood before this cycle, so a
    // pair arriving in the commit cycle waits for the next frame.
    if (commit) begin
      if (pend_valid_q) begin
        act_l_d = pend_l_q;
        act_r_d = pend_r_q;
      end
      pend_valid_d = 1'b0;
    end

    if (new_sample_in) begin
      pend_l_d     = left_sample_in;
      pend_r_d     = right_sample_in;
      pend_valid_d = 1'b1;
    end

    frame_start_d = commit;
    underrun_d    = commit & ~pend_valid_q;
    overrun_out   = new_sample_in & pend_valid_q & ~commit;

    if (bclk_fall) begin
      data_d = 1'b0;
      if (commit) begin
        shift_d = act_l_d;
      end else if (slot_next == R_LOAD) begin
        shift_d = act_r_q;
      end else if (in_data_slot) begin
        data_d  = shift_q[SAMPLE_W-1];
        shift_d = {shift_q[SAMPLE_W-2:0], 1'b0};
      end
    end
  end

  assign i2s_data_out    = data_q;
  assign frame_start_out = frame_start_q;
  assign underrun_out    = underrun_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// tb/tb_i2s_transmitter.sv - self-checking bench for i2s_transmitter
module tb_i2s_transmitter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [15:0] left_sample_in;
  logic [15:0] right_sample_in;
  logic        new_sample_in;
  logic        i2s_bclk_out;
  logic        i2s_lrclk_out;
  logic        i2s_data_out;
  logic        frame_start_out;
  logic        underrun_out;
  logic        overrun_out;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          npulse;
    logic [15:0] l1;
    logic [15:0] r1;
    logic [15:0] l2;
    logic [15:0] r2;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
    logic        exp_ur;
  } vec_t;

  vec_t vecs[5];

  always #5 clk_in = ~clk_in;

  i2s_transmitter #(
    .BCLK_HALF(12),
    .SAMPLE_W (16)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .left_sample_in (left_sample_in),
    .right_sample_in(right_sample_in),
    .new_sample_in  (new_sample_in),
    .i2s_bclk_out   (i2s_bclk_out),
    .i2s_lrclk_out  (i2s_lrclk_out),
    .i2s_data_out   (i2s_data_out),
    .frame_start_out(frame_start_out),
    .underrun_out   (underrun_out),
    .overrun_out    (overrun_out)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timed_out(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timeout waiting for DUT event", name);
  endtask

  function automatic logic [63:0] frame_of(input logic [15:0] l, input logic [15:0] r);
    logic [63:0] f;
    f = '0;
    for (int k = 0; k < 16; k++) begin
      f[1 + k]  = l[15 - k];
      f[33 + k] = r[15 - k];
    end
    return f;
  endfunction

  // Counts falling clk_in edges until frame_start_out is seen.
  task automatic wait_fs(output int cyc);
    bit found;
    found = 1'b0;
    cyc   = -1;
    for (int i = 1; i <= 2000 && !found; i++) begin
      @(negedge clk_in);
      if (frame_start_out) begin
        found = 1'b1;
        cyc   = i;
      end
    end
    if (!found) timed_out("wait_frame_start");
  endtask

  task automatic wait_rise(output int cyc);
    bit   found;
    logic prev;
    found = 1'b0;
    cyc   = -1;
    prev  = i2s_bclk_out;
    for (int i = 1; i <= 100 && !found; i++) begin
      @(negedge clk_in);
      if (!prev && i2s_bclk_out) begin
        found = 1'b1;
        cyc   = i;
      end
      prev = i2s_bclk_out;
    end
    if (!found) timed_out("wait_bclk_rise");
  endtask

  // Samples data/LRCLK at each BCLK rise; index = slot, starting at slot 0.
  task automatic capture(output logic [63:0] d, output logic [63:0] lr);
    int c;
    d  = '0;
    lr = '0;
    for (int s = 0; s < 64; s++) begin
      wait_rise(c);
      d[s]  = i2s_data_out;
      lr[s] = i2s_lrclk_out;
    end
  endtask

  task automatic pulse(input logic [15:0] l, input logic [15:0] r, input logic exp_ov,
                       input string name);
    @(negedge clk_in);
    left_sample_in  = l;
    right_sample_in = r;
    new_sample_in   = 1'b1;
    #1;
    check(name, 64'(overrun_out), 64'(exp_ov));
    @(negedge clk_in);
    new_sample_in = 1'b0;
  endtask

  initial begin
    int          c;
    logic [63:0] d;
    logic [63:0] lr;
    logic [63:0] lr_exp;

    lr_exp = {32'hFFFF_FFFF, 32'h0000_0000};

    vecs[0] = '{1, 16'hA5C3, 16'h8001, 16'h0000, 16'h0000, 16'hA5C3, 16'h8001, 1'b0};
    vecs[1] = '{0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hA5C3, 16'h8001, 1'b1};
    vecs[2] = '{2, 16'h1111, 16'h1111, 16'h2222, 16'h2222, 16'h2222, 16'h2222, 1'b0};
    vecs[3] = '{1, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h7FFF, 16'hFFFF, 1'b0};
    vecs[4] = '{1, 16'h0001, 16'h8000, 16'h0000, 16'h0000, 16'h0001, 16'h8000, 1'b0};

    rst_in          = 1'b0;
    new_sample_in   = 1'b0;
    left_sample_in  = '0;
    right_sample_in = '0;
    repeat (3) @(negedge clk_in);
    check("reset_outputs", 64'({i2s_bclk_out, i2s_lrclk_out, i2s_data_out,
                                frame_start_out, underrun_out, overrun_out}), 64'd0);

    rst_in = 1'b1;
    wait_fs(c);
    check("first_fs_latency", 64'(c), 64'd24);
    check("first_fs_underrun", 64'(underrun_out), 64'd1);
    wait_fs(c);
    check("fs_period", 64'(c), 64'd1536);
    check("second_fs_underrun", 64'(underrun_out), 64'd1);
    wait_rise(c);
    wait_rise(c);
    check("bclk_period", 64'(c), 64'd24);

    for (int v = 0; v < 5; v++) begin
      wait_fs(c);
      if (vecs[v].npulse >= 1)
        pulse(vecs[v].l1, vecs[v].r1, 1'b0, $sformatf("vec%0d_overrun_first", v));
      if (vecs[v].npulse >= 2) begin
        repeat (5) @(negedge clk_in);
        pulse(vecs[v].l2, vecs[v].r2, 1'b1, $sformatf("vec%0d_overrun_second", v));
      end
      wait_fs(c);
      check($sformatf("vec%0d_underrun", v), 64'(underrun_out), 64'(vecs[v].exp_ur));
      capture(d, lr);
      check($sformatf("vec%0d_data", v), d, frame_of(vecs[v].exp_l, vecs[v].exp_r));
      check($sformatf("vec%0d_lrclk", v), lr, lr_exp);
    end

    // new_sample_in landing exactly in the commit cycle.
    wait_fs(c);
    for (int i = 1; i <= 1535; i++) begin
      @(negedge clk_in);
      new_sample_in = 1'b0;
      if (i == 5) begin
        left_sample_in  = 16'h1234;
        right_sample_in = 16'h5678;
        new_sample_in   = 1'b1;
        #1;
        check("commit_seq_overrun_early", 64'(overrun_out), 64'd0);
      end
      if (i == 1535) begin
        left_sample_in  = 16'hC0DE;
        right_sample_in = 16'h3C5A;
        new_sample_in   = 1'b1;
        #1;
        check("commit_seq_overrun_coincident", 64'(overrun_out), 64'd0);
      end
    end
    @(negedge clk_in);
    new_sample_in = 1'b0;
    check("commit_seq_fs_aligned", 64'(frame_start_out), 64'd1);
    check("commit_seq_underrun", 64'(underrun_out), 64'd0);
    capture(d, lr);
    check("commit_seq_old_pair", d, frame_of(16'h1234, 16'h5678));
    wait_fs(c);
    check("commit_seq_next_underrun", 64'(underrun_out), 64'd0);
    capture(d, lr);
    check("commit_seq_new_pair", d, frame_of(16'hC0DE, 16'h3C5A));

    // Reset asserted mid-frame during slot 20 with a pair pending.
    wait_fs(c);
    pulse(16'hFFFF, 16'hFFFF, 1'b0, "midreset_pending_overrun");
    for (int s = 0; s < 21; s++) wait_rise(c);
    check("midreset_bclk_high", 64'(i2s_bclk_out), 64'd1);
    #2;
    rst_in = 1'b0;
    #1;
    check("midreset_async_outputs", 64'({i2s_bclk_out, i2s_lrclk_out, i2s_data_out,
                                         frame_start_out, underrun_out, overrun_out}), 64'd0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    wait_fs(c);
    check("midreset_fs_latency", 64'(c), 64'd24);
    check("midreset_fs_underrun", 64'(underrun_out), 64'd1);
    capture(d, lr);
    check("midreset_frame_cleared", d, 64'd0);
    check("midreset_lrclk", lr, lr_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
